qif_synapse_current: RTL and testbench

Spike-to-current synapse front end for the 8-bit QIF neuron. It takes up to N_SYN binary spike lines, weights each with a programmable signed 8-bit weight, and sums them into a saturating, exponentially decaying synaptic current. The output `i_syn` is the signed 8-bit input the QIF membrane integrator consumes, so this block drives the neuron from the other side of its current interface.

---
 rtl/qif_pkg.sv | 36 +++
 rtl/qif_syn_weights.sv | 35 +++
 rtl/qif_synapse_current.sv | 75 +++++++
 tb/tb_qif_synapse_current.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/qif_pkg.sv
// Shared widths and saturation helpers for the QIF neuron and its synapse front end.
package qif_pkg;

  localparam int I_W   = 8;
  localparam int ACC_W = 12;

  localparam logic signed [I_W-1:0]   I_MAX   = 8'sh7F;
  localparam logic signed [I_W-1:0]   I_MIN   = 8'sh80;
  localparam logic signed [ACC_W-1:0] ACC_MAX = 12'sh07F;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 12'shF80;

  typedef struct packed {
    logic signed [I_W-1:0] val;
    logic                  clamped;
  } sat_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [I_W-1:0] v);
    return {{(ACC_W-I_W){v[I_W-1]}}, v};
  endfunction

  function automatic sat_t sat_i(input logic signed [ACC_W-1:0] x);
    sat_t r;
    if (x > ACC_MAX) begin
      r.val     = I_MAX;
      r.clamped = 1'b1;
    end else if (x < ACC_MIN) begin
      r.val     = I_MIN;
      r.clamped = 1'b1;
    end else begin
      r.val     = x[I_W-1:0];
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qif_syn_weights.sv
// Per-synapse signed weight registers and the weighted sum of the registered spike vector.
import qif_pkg::*;

module qif_syn_weights #(
  parameter int  N_SYN = 4,
  localparam int AW    = $clog2(N_SYN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [I_W-1:0]          wr_data,
  input  logic [N_SYN-1:0]        spike_q,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [I_W-1:0] w [N_SYN];

  // Addresses with no matching slot simply match nothing, so they are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_SYN; k++) w[k] <= '0;
    end else begin
      for (int k = 0; k < N_SYN; k++)
        if (wr_en && wr_addr == AW'(k)) w[k] <= wr_data;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N_SYN; k++)
      if (spike_q[k]) sum = sum + sext(w[k]);
  end

endmodule

// File: rtl/qif_synapse_current.sv
// Synaptic current accumulator: weighted spike sum plus per-tick exponential decay, saturated to 8 bits.
import qif_pkg::*;

module qif_synapse_current #(
  parameter int  N_SYN       = 4,
  parameter int  DECAY_SHIFT = 3,
  localparam int AW          = $clog2(N_SYN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [N_SYN-1:0] spike_in,
  input  logic             tick,
  input  logic             w_wr_en,
  input  logic [AW-1:0]    w_wr_addr,
  input  logic [7:0]       w_wr_data,
  input  logic             sat_clr,
  output logic [7:0]       i_syn,
  output logic             sat_flag,
  output logic [7:0]       spike_cnt
);

  logic [N_SYN-1:0]        spike_q;
  logic signed [ACC_W-1:0] sum;
  logic signed [I_W-1:0]   i_cur;
  logic signed [I_W-1:0]   d;
  logic signed [ACC_W-1:0] acc;
  logic [7:0]              pop;
  sat_t                    sat;

  qif_syn_weights #(.N_SYN(N_SYN)) u_weights (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_addr (w_wr_addr),
    .wr_data (w_wr_data),
    .spike_q (spike_q),
    .sum     (sum)
  );

  assign i_cur = i_syn;

  // Positive currents would stall at 1..7 under a plain shift; the forced step lets them reach 0.
  always_comb begin
    d = '0;
    if (tick && ena) begin
      d = i_cur >>> DECAY_SHIFT;
      if (i_cur > 0 && d == 0) d = 8'sd1;
    end
  end

  assign acc = sext(i_cur) - sext(d) + sum;
  assign sat = sat_i(acc);

  always_comb begin
    pop = '0;
    for (int k = 0; k < N_SYN; k++) pop = pop + 8'(spike_q[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_q   <= '0;
      i_syn     <= '0;
      sat_flag  <= 1'b0;
      spike_cnt <= '0;
    end else begin
      spike_q   <= ena ? spike_in : '0;
      spike_cnt <= spike_cnt + pop;
      if (ena) i_syn <= sat.val;
      if (ena && sat.clamped) sat_flag <= 1'b1;
      else if (sat_clr)       sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qif_synapse_current.sv
// Scoreboard bench for qif_synapse_current: directed vectors queue expected outputs, a monitor checks them.
module tb_qif_synapse_current;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] spike_in = '0;
  logic       tick = 1'b0;
  logic       w_wr_en = 1'b0;
  logic [1:0] w_wr_addr = '0;
  logic [7:0] w_wr_data = '0;
  logic       sat_clr = 1'b0;
  logic [7:0] i_syn;
  logic       sat_flag;
  logic [7:0] spike_cnt;

  qif_synapse_current #(.N_SYN(4), .DECAY_SHIFT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .spike_in  (spike_in),
    .tick      (tick),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .sat_clr   (sat_clr),
    .i_syn     (i_syn),
    .sat_flag  (sat_flag),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 tag;
    int                 id;
    logic signed [7:0]  ei;
    logic               es;
    logic [7:0]         ec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].tag <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ($signed(i_syn) !== e.ei || sat_flag !== e.es || spike_cnt !== e.ec) begin
        failures++;
        $display("FAIL vec%0d cyc=%0d got i_syn=%0d sat=%0b cnt=%0d want i_syn=%0d sat=%0b cnt=%0d",
                 e.id, cyc, $signed(i_syn), sat_flag, spike_cnt, e.ei, e.es, e.ec);
      end
    end
  end

  int vid = 0;

  // Drive one cycle of inputs at a negedge; optionally queue the outputs expected after the next posedge.
  task automatic apply(input logic [3:0] sp, input logic tk, input logic we, input logic [1:0] wa,
                       input logic [7:0] wd, input logic clr, input logic en, input logic chk,
                       input logic signed [7:0] ei, input logic es, input logic [7:0] ec);
    exp_t e;
    spike_in = sp; tick = tk; w_wr_en = we; w_wr_addr = wa; w_wr_data = wd;
    sat_clr = clr; ena = en;
    if (chk) begin
      vid++;
      e.tag = cyc + 1; e.id = vid; e.ei = ei; e.es = es; e.ec = ec;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    apply(4'b0, 1'b0, 1'b1, a, v, 1'b0, 1'b1, 1'b0, 8'sd0, 1'b0, 8'd0);
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (i_syn !== 8'd0 || sat_flag !== 1'b0 || spike_cnt !== 8'd0) begin
      failures++;
      $display("FAIL %s got i_syn=%0d sat=%0b cnt=%0d want all zero", nm, $signed(i_syn), sat_flag, spike_cnt);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string nm);
    spike_in = '0; tick = 1'b0; w_wr_en = 1'b0; sat_clr = 1'b0; ena = 1'b1;
    #2 reset = 1'b1;
    #1 chk_zero(nm);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #3 chk_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous spikes with mixed-sign weights
    wr(2'd0, 8'd20);
    wr(2'd1, 8'hF6);
    apply(4'b0011, 0, 0, 0, 0, 0, 1, 1,  8'sd0,  0, 8'd0);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1,  8'sd10, 0, 8'd2);

    // Positive saturation, then flag clear
    do_reset("reset_t2");
    wr(2'd0, 8'd100);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 1, 8'sd0,   0, 8'd0);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 1, 8'sd100, 0, 8'd1);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd127, 1, 8'd2);
    apply(4'b0000, 0, 0, 0, 0, 1, 1, 1, 8'sd127, 0, 8'd2);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd127, 0, 8'd2);

    // Decay from 64
    do_reset("reset_t3");
    wr(2'd0, 8'd64);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 0, 8'sd0,  0, 8'd0);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd64, 0, 8'd1);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd56, 0, 8'd1);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd49, 0, 8'd1);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd43, 0, 8'd1);

    // Small positive and negative decay to zero
    do_reset("reset_t4");
    wr(2'd0, 8'd5);
    wr(2'd1, 8'hF9);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 0, 8'sd0,  0, 8'd0);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd5,  0, 8'd1);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd4,  0, 8'd1);
    apply(4'b0010, 0, 0, 0, 0, 0, 1, 1, 8'sd4,  0, 8'd1);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, -8'sd3, 0, 8'd2);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, -8'sd2, 0, 8'd2);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, -8'sd1, 0, 8'd2);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd0,  0, 8'd2);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd0,  0, 8'd2);

    // Tick and spike applied in the same update
    do_reset("reset_t5");
    wr(2'd0, 8'd64);
    wr(2'd2, 8'd8);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 0, 8'sd0,  0, 8'd0);
    apply(4'b0100, 0, 0, 0, 0, 0, 1, 1, 8'sd64, 0, 8'd1);
    apply(4'b0000, 1, 0, 0, 0, 0, 1, 1, 8'sd64, 0, 8'd2);

    // Write on the sampling edge, then enable gating
    do_reset("reset_t6");
    wr(2'd0, 8'd5);
    apply(4'b0001, 0, 1, 2'd0, 8'd30, 0, 1, 1, 8'sd0,  0, 8'd0);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd30, 0, 8'd1);
    apply(4'b0001, 1, 0, 0, 0, 0, 0, 1, 8'sd30, 0, 8'd1);
    apply(4'b0011, 1, 1, 2'd1, 8'd7, 0, 0, 1, 8'sd30, 0, 8'd1);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd30, 0, 8'd1);
    apply(4'b0010, 0, 0, 0, 0, 0, 1, 1, 8'sd30, 0, 8'd1);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd37, 0, 8'd2);

    // Reset with a spike in flight clears weights too
    do_reset("reset_t7");
    wr(2'd0, 8'd90);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 0, 8'sd0,  0, 8'd0);
    apply(4'b0001, 0, 0, 0, 0, 0, 1, 1, 8'sd90, 0, 8'd1);
    do_reset("reset_midflight");
    apply(4'b1111, 0, 0, 0, 0, 0, 1, 1, 8'sd0, 0, 8'd0);
    apply(4'b0000, 0, 0, 0, 0, 0, 1, 1, 8'sd0, 0, 8'd4);

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
